// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register
// offsets, STATUS bit positions and the serializer state encoding.
package uart_tx_pkg;

  localparam logic [31:0] TXDATA_OFS = 32'd0;
  localparam logic [31:0] STATUS_OFS = 32'd4;

  localparam int STAT_BUSY  = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_EMPTY = 2;
  localparam int STAT_OVF   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } txState_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO feeding the serializer. Pointers carry one
// extra wrap bit so full and empty are told apart without a separate counter.
// The head entry is presented on dout before it is popped.
module uart_tx_fifo
  import uart_tx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [AW:0] wrPtr_q, wrPtr_d;
  logic [AW:0] rdPtr_q, rdPtr_d;
  logic [7:0]  mem_q [DEPTH];
  logic        doPush;
  logic        doPop;

  assign full   = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign empty  = (wrPtr_q == rdPtr_q);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign dout   = mem_q[rdPtr_q[AW-1:0]];

  // Advance each pointer independently; a push and a pop on one edge leave the count unchanged.
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doPush) wrPtr_d = wrPtr_q + PTR_ONE;
    if (doPop)  rdPtr_d = rdPtr_q + PTR_ONE;
  end

  // Pointer registers; clearing them discards anything still queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage array needs no reset because the pointers alone define validity.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_peripheral.sv
// Memory-mapped 8N1 UART transmitter. Bytes stored to TXDATA are queued in a
// FIFO and shifted out LSB first; STATUS reports busy/full/empty/overflow.
module uart_tx_peripheral
  import uart_tx_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter logic [31:0] BASE_ADDR    = 32'h1001_0030
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Adr_in,
  input  logic        MemWrite_in,
  input  logic [31:0] Data_in,
  output logic [31:0] Data_out,
  output logic        tx_out,
  output logic        tx_busy
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [31:0] TXDATA_ADDR = BASE_ADDR + TXDATA_OFS;
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + STATUS_OFS;

  txState_e      state_q, state_d;
  logic [CW-1:0] baud_q, baud_d;
  logic [2:0]    bitIdx_q, bitIdx_d;
  logic [7:0]    shift_q, shift_d;
  logic          ovf_q, ovf_d;

  logic          wrTxData;
  logic          wrStatus;
  logic          fifoPop;
  logic          fifoFull;
  logic          fifoEmpty;
  logic [7:0]    fifoDout;
  logic          unusedDataHi;

  assign wrTxData     = MemWrite_in && (Adr_in == TXDATA_ADDR);
  assign wrStatus     = MemWrite_in && (Adr_in == STATUS_ADDR);
  assign unusedDataHi = ^Data_in[31:8];

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (wrTxData),
    .din  (Data_in[7:0]),
    .pop  (fifoPop),
    .dout (fifoDout),
    .full (fifoFull),
    .empty(fifoEmpty)
  );

  // Sticky overflow: set by a dropped TXDATA write, cleared by writing 1 to its STATUS bit.
  always_comb begin
    ovf_d = ovf_q;
    if (wrTxData && fifoFull) begin
      ovf_d = 1'b1;
    end else if (wrStatus && Data_in[STAT_OVF]) begin
      ovf_d = 1'b0;
    end
  end

  // Serializer state register together with its baud, bit and shift datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      ovf_q    <= ovf_d;
    end
  end

  // Next-state logic: each bit period ends when the baud counter reaches zero.
  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    fifoPop  = 1'b0;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifoEmpty) begin
          fifoPop = 1'b1;
          shift_d = fifoDout;
          baud_d  = BAUD_LOAD;
          state_d = START;
        end
      end
      START: begin
        if (baud_q == '0) begin
          baud_d   = BAUD_LOAD;
          bitIdx_d = '0;
          state_d  = DATA;
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      DATA: begin
        if (baud_q == '0) begin
          baud_d  = BAUD_LOAD;
          shift_d = {1'b0, shift_q[7:1]};
          if (bitIdx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bitIdx_d = bitIdx_q + 3'd1;
          end
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      STOP: begin
        if (baud_q == '0) begin
          if (!fifoEmpty) begin
            fifoPop = 1'b1;
            shift_d = fifoDout;
            baud_d  = BAUD_LOAD;
            state_d = START;
          end else begin
            baud_d  = '0;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - BAUD_ONE;
        end
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Line level and busy flag decoded from the current state.
  always_comb begin
    tx_out  = 1'b1;
    tx_busy = (state_q != IDLE);
    case (state_q)
      IDLE:    tx_out = 1'b1;
      START:   tx_out = 1'b0;
      DATA:    tx_out = shift_q[0];
      STOP:    tx_out = 1'b1;
      default: tx_out = 1'b1;
    endcase
  end

  // Read mux: only STATUS returns data, TXDATA and unmapped addresses read zero.
  always_comb begin
    Data_out = '0;
    if (Adr_in == STATUS_ADDR) begin
      Data_out[STAT_BUSY]  = tx_busy;
      Data_out[STAT_FULL]  = fifoFull;
      Data_out[STAT_EMPTY] = fifoEmpty;
      Data_out[STAT_OVF]   = ovf_q;
    end
  end

endmodule

// File: tb/tb_uart_tx_peripheral.sv
// Directed self-checking bench for uart_tx_peripheral with a 4-cycle bit
// period and a 4-entry FIFO.
module tb_uart_tx_peripheral;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  localparam logic [31:0] BASE     = 32'h1001_0030;
  localparam logic [31:0] STATUS   = 32'h1001_0034;
  localparam logic [31:0] UNMAPPED = 32'h1001_0040;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] Adr_in = UNMAPPED;
  logic        MemWrite_in = 1'b0;
  logic [31:0] Data_in = 32'h0;
  logic [31:0] Data_out;
  logic        tx_out;
  logic        tx_busy;

  int checks   = 0;
  int failures = 0;

  logic logEn = 1'b0;
  logic lineLog [$];

  uart_tx_peripheral #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH),
    .BASE_ADDR   (BASE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .Adr_in     (Adr_in),
    .MemWrite_in(MemWrite_in),
    .Data_in    (Data_in),
    .Data_out   (Data_out),
    .tx_out     (tx_out),
    .tx_busy    (tx_busy)
  );

  // Free-running clock, period 10 time units.
  always #5 clk = ~clk;

  // Record the serial line on every busy cycle while logging is enabled.
  always @(negedge clk) begin
    if (logEn && tx_busy) lineLog.push_back(tx_out);
  end

  // Expected line level at a given cycle within a frame carrying byte b.
  function automatic logic expLine(input logic [7:0] b, input int pos);
    int bitn;
    bitn = pos / CPB;
    if (bitn == 0) return 1'b0;
    if (bitn == 9) return 1'b1;
    return b[bitn-1];
  endfunction

  task automatic busWrite(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    Adr_in      = addr;
    Data_in     = data;
    MemWrite_in = 1'b1;
  endtask

  task automatic busRelease();
    @(negedge clk);
    MemWrite_in = 1'b0;
    Adr_in      = UNMAPPED;
    Data_in     = 32'h0;
  endtask

  task automatic readReg(input logic [31:0] addr, output logic [31:0] data);
    Adr_in = addr;
    #1;
    data = Data_out;
  endtask

  task automatic waitIdle(input int budget, output logic timedOut);
    timedOut = 1'b1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!tx_busy) begin
        timedOut = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checks++;
    if (tx_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL reset_tx_out: got %b expected 1", tx_out);
    end
    checks++;
    if (tx_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_busy: got %b expected 0", tx_busy);
    end
    readReg(STATUS, rd);
    checks++;
    if (rd !== 32'h0000_0004) begin
      failures++;
      $display("[TB] FAIL reset_status: got %h expected 00000004", rd);
    end
    readReg(BASE, rd);
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("[TB] FAIL txdata_read: got %h expected 00000000", rd);
    end
  endtask

  task automatic test_single_frame();
    logic        seqA5 [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [31:0] rd;
    int          badCycles;
    busWrite(BASE, 32'hFFFF_FFA5);
    busRelease();
    checks++;
    if (tx_out !== 1'b1 || tx_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL a5_latency: got tx=%b busy=%b expected tx=1 busy=0", tx_out, tx_busy);
    end
    badCycles = 0;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        checks++;
        if (tx_out !== seqA5[b] || tx_busy !== 1'b1) begin
          failures++;
          $display("[TB] FAIL a5_bit%0d_cyc%0d: got tx=%b busy=%b expected tx=%b busy=1",
                   b, c, tx_out, tx_busy, seqA5[b]);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (tx_busy !== 1'b0 || tx_out !== 1'b1) begin
      failures++;
      $display("[TB] FAIL a5_end: got tx=%b busy=%b expected tx=1 busy=0", tx_out, tx_busy);
    end
    readReg(STATUS, rd);
    checks++;
    if (rd !== 32'h0000_0004) begin
      failures++;
      $display("[TB] FAIL a5_status: got %h expected 00000004", rd);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes [3] = '{8'h01, 8'h02, 8'h03};
    logic       timedOut;
    int         firstBad;
    lineLog.delete();
    logEn = 1'b1;
    for (int i = 0; i < 3; i++) busWrite(BASE, {24'h0, bytes[i]});
    busRelease();
    waitIdle(4 * FRAME, timedOut);
    logEn = 1'b0;
    checks++;
    if (timedOut) begin
      failures++;
      $display("[TB] FAIL b2b_timeout: got busy=1 expected idle within %0d cycles", 4 * FRAME);
    end
    checks++;
    if (lineLog.size() != 3 * FRAME) begin
      failures++;
      $display("[TB] FAIL b2b_busy_cycles: got %0d expected %0d", lineLog.size(), 3 * FRAME);
    end
    firstBad = -1;
    for (int k = 0; k < lineLog.size() && k < 3 * FRAME; k++) begin
      if (firstBad < 0 && lineLog[k] !== expLine(bytes[k / FRAME], k % FRAME)) firstBad = k;
    end
    checks++;
    if (firstBad >= 0) begin
      failures++;
      $display("[TB] FAIL b2b_line: got %b at cycle %0d expected %b", lineLog[firstBad], firstBad,
               expLine(bytes[firstBad / FRAME], firstBad % FRAME));
    end
  endtask

  task automatic test_overflow();
    logic [7:0]  bytes [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    logic [31:0] rd;
    logic        timedOut;
    int          firstBad;
    lineLog.delete();
    logEn = 1'b1;
    for (int i = 0; i < 6; i++) busWrite(BASE, {24'h0, bytes[i]});
    busRelease();
    readReg(STATUS, rd);
    checks++;
    if (rd !== 32'h0000_000B) begin
      failures++;
      $display("[TB] FAIL ovf_status_set: got %h expected 0000000b", rd);
    end
    busWrite(STATUS, 32'h0000_0008);
    busRelease();
    readReg(STATUS, rd);
    checks++;
    if (rd !== 32'h0000_0003) begin
      failures++;
      $display("[TB] FAIL ovf_status_clear: got %h expected 00000003", rd);
    end
    waitIdle(6 * FRAME, timedOut);
    logEn = 1'b0;
    checks++;
    if (timedOut) begin
      failures++;
      $display("[TB] FAIL ovf_timeout: got busy=1 expected idle within %0d cycles", 6 * FRAME);
    end
    checks++;
    if (lineLog.size() != 5 * FRAME) begin
      failures++;
      $display("[TB] FAIL ovf_busy_cycles: got %0d expected %0d", lineLog.size(), 5 * FRAME);
    end
    firstBad = -1;
    for (int k = 0; k < lineLog.size() && k < 5 * FRAME; k++) begin
      if (firstBad < 0 && lineLog[k] !== expLine(bytes[k / FRAME], k % FRAME)) firstBad = k;
    end
    checks++;
    if (firstBad >= 0) begin
      failures++;
      $display("[TB] FAIL ovf_line: got %b at cycle %0d expected %b", lineLog[firstBad], firstBad,
               expLine(bytes[firstBad / FRAME], firstBad % FRAME));
    end
    readReg(STATUS, rd);
    checks++;
    if (rd !== 32'h0000_0004) begin
      failures++;
      $display("[TB] FAIL ovf_status_end: got %h expected 00000004", rd);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] rd;
    int          activity;
    busWrite(BASE, 32'h0000_00C3);
    busWrite(BASE, 32'h0000_003C);
    busWrite(BASE, 32'h0000_0099);
    busRelease();
    repeat (8) @(negedge clk);
    checks++;
    if (tx_busy !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrst_pre_busy: got %b expected 1", tx_busy);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || tx_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL midrst_line: got tx=%b busy=%b expected tx=1 busy=0", tx_out, tx_busy);
    end
    rst = 1'b0;
    readReg(STATUS, rd);
    checks++;
    if (rd !== 32'h0000_0004) begin
      failures++;
      $display("[TB] FAIL midrst_status: got %h expected 00000004", rd);
    end
    activity = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (tx_busy !== 1'b0 || tx_out !== 1'b1) activity++;
    end
    checks++;
    if (activity != 0) begin
      failures++;
      $display("[TB] FAIL midrst_no_frames: got %0d active cycles expected 0", activity);
    end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd;
    int          activity;
    busWrite(UNMAPPED, 32'h0000_0055);
    busRelease();
    busWrite(STATUS, 32'h0000_0055);
    busRelease();
    readReg(UNMAPPED, rd);
    checks++;
    if (rd !== 32'h0) begin
      failures++;
      $display("[TB] FAIL unmapped_read: got %h expected 00000000", rd);
    end
    activity = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (tx_busy !== 1'b0 || tx_out !== 1'b1) activity++;
    end
    checks++;
    if (activity != 0) begin
      failures++;
      $display("[TB] FAIL unmapped_no_frame: got %0d active cycles expected 0", activity);
    end
    readReg(STATUS, rd);
    checks++;
    if (rd !== 32'h0000_0004) begin
      failures++;
      $display("[TB] FAIL unmapped_status: got %h expected 00000004", rd);
    end
  endtask

  // Top-level sequence of scenarios followed by the summary line.
  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_unmapped();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before time 200000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
